rr_mux_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the shared 4:1 multiplexer (inputs a,b,c,d -> m).

---
 rtl/rr_mux_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Grants are held up to MAX_HOLD cycles; the selected data is registered with a valid flag.
module rr_mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] m,
    output logic             valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [1:0]       last_q, last_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             valid_q, valid_d;

    logic [1:0]       pick_base;
    logic [2:0]       pick;
    logic             keep;
    logic [WIDTH-1:0] mux_data;

    // Returns {found, index}; the search starts just after base and wraps through base itself.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        mux_data = a;
        case (sel_q)
            2'd0: mux_data = a;
            2'd1: mux_data = b;
            2'd2: mux_data = c;
            2'd3: mux_data = d;
            default: mux_data = a;
        endcase
    end

    assign pick_base = (state_q == BUSY) ? sel_q : last_q;
    assign pick      = rr_pick(req, pick_base);
    assign keep      = (state_q == BUSY) && req[sel_q] && (hold_cnt_q < MAX_HOLD_C);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        m_d        = (state_q == BUSY) ? mux_data : '0;
        valid_d    = (state_q == BUSY);

        if (keep) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end else begin
            if (state_q == BUSY) begin
                last_d = sel_q;
            end
            // A release re-arbitrates on the same edge so back-to-back grants leave no bubble.
            if (pick[2]) begin
                state_d    = BUSY;
                gnt_d      = 4'b0001 << pick[1:0];
                sel_d      = pick[1:0];
                hold_cnt_d = 4'd1;
            end else begin
                state_d    = IDLE;
                gnt_d      = 4'b0000;
                hold_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            hold_cnt_q <= 4'd0;
            last_q     <= 2'd3;
            m_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            m_q        <= m_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign m     = m_q;
    assign valid = valid_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_sel:    assert property (@(posedge clk) disable iff (rst) (gnt_q != 4'b0000) |-> gnt_q[sel_q]);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized bench for rr_mux_arbiter against a cycle-level reference model,
// plus directed reset, single-request, fairness, sole-holder, early-drop and rotation cases.
module tb_rr_mux_arbiter;

    localparam int W  = 4;
    localparam int MH = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   gnt;
    logic         s1, s0;
    logic [W-1:0] m;
    logic         valid;

    int checks;
    int errors;

    // Reference model state
    bit           md_busy;
    int           md_sel;
    int           md_hold;
    int           md_last;
    logic [3:0]   exp_gnt;
    logic [W-1:0] exp_m;
    logic         exp_valid;

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .m     (m),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        md_busy   = 1'b0;
        md_sel    = 0;
        md_hold   = 0;
        md_last   = 3;
        exp_gnt   = 4'b0000;
        exp_m     = '0;
        exp_valid = 1'b0;
    endtask

    // One clock edge of the arbiter, computed from the rotation and hold rules.
    task automatic modelStep();
        logic [W-1:0] dv [4];
        int  base;
        int  winner;
        bit  found;
        dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
        exp_valid = md_busy;
        exp_m     = md_busy ? dv[md_sel] : '0;
        if (md_busy && req[md_sel] && md_hold < MH) begin
            md_hold++;
        end else begin
            base = md_busy ? md_sel : md_last;
            if (md_busy) md_last = md_sel;
            found  = 1'b0;
            winner = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req[(base + k) % 4]) begin
                    found  = 1'b1;
                    winner = (base + k) % 4;
                end
            end
            if (found) begin
                md_busy = 1'b1;
                md_sel  = winner;
                md_hold = 1;
            end else begin
                md_busy = 1'b0;
                md_hold = 0;
            end
        end
        exp_gnt = md_busy ? (4'b0001 << md_sel) : 4'b0000;
    endtask

    // Called at a falling edge; drives inputs, advances one rising edge, compares, returns at next falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [W-1:0] da, input logic [W-1:0] db,
                                 input logic [W-1:0] dc, input logic [W-1:0] dd);
        req = r; a = da; b = db; c = dc; d = dd;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("gnt",   32'(gnt),        32'(exp_gnt));
        checkOutput("sel",   32'({s1, s0}),   32'(md_sel));
        checkOutput("m",     32'(m),          32'(exp_m));
        checkOutput("valid", 32'(valid),      32'(exp_valid));
        @(negedge clk);
    endtask

    task automatic applyRandom(input logic [3:0] r);
        applyStimulus(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Asserts reset mid-cycle and checks outputs clear before any clock edge.
    task automatic doReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_gnt",   32'(gnt),      32'h0);
        checkOutput("rst_sel",   32'({s1, s0}), 32'h0);
        checkOutput("rst_m",     32'(m),        32'h0);
        checkOutput("rst_valid", 32'(valid),    32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] cur_req;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req = 4'b0000;
        a = '0; b = '0; c = '0; d = '0;
        modelReset();
        #1 rst = 1'b1;
        #2;
        checkOutput("init_gnt",   32'(gnt),      32'h0);
        checkOutput("init_sel",   32'({s1, s0}), 32'h0);
        checkOutput("init_valid", 32'(valid),    32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single requester");
        applyStimulus(4'b0001, 4'd1, 4'd0, 4'd0, 4'd0);
        checkOutput("single_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0001, 4'd1, 4'd0, 4'd0, 4'd0);
        checkOutput("single_valid", 32'(valid), 32'h1);
        checkOutput("single_m",     32'(m),     32'h1);
        applyRandom(4'b0000);
        applyRandom(4'b0000);
        doReset();

        $display("[TB] fairness with all requesting");
        for (int k = 0; k < 20; k++) begin
            applyRandom(4'b1111);
            checkOutput("fair_gnt", 32'(gnt), 32'(4'b0001 << ((k / MH) % 4)));
        end
        doReset();

        $display("[TB] sole holder");
        for (int k = 0; k < 12; k++) begin
            applyRandom(4'b0100);
            checkOutput("sole_gnt", 32'(gnt), 32'h4);
            if (k > 0) begin
                checkOutput("sole_valid", 32'(valid), 32'h1);
                checkOutput("sole_m",     32'(m),     32'(c));
            end
        end
        doReset();

        $display("[TB] early drop");
        repeat (3) applyRandom(4'b0010);
        applyRandom(4'b1000);
        checkOutput("drop_gnt", 32'(gnt),      32'h8);
        checkOutput("drop_sel", 32'({s1, s0}), 32'h3);
        doReset();

        $display("[TB] rotation restored by reset");
        applyRandom(4'b0100);
        checkOutput("rot_first", 32'(gnt), 32'h4);
        doReset();
        applyRandom(4'b1111);
        checkOutput("rot_after_rst", 32'(gnt), 32'h1);

        $display("[TB] randomized traffic");
        cur_req = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 249) == 0) doReset();
            applyRandom(cur_req);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
